// File: rtl/alu_pkg.sv
// Shared opcode and status-flag definitions for the alu and its result stage.
// upd_mask gives the {N,Z,C,V} bits an opcode is allowed to write.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_SRA;
    endfunction

    function automatic logic [3:0] upd_mask(input logic [3:0] op);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            OP_ADD, OP_SUB: m = 4'b1111;
            OP_SHL, OP_SHR: m = 4'b1110;
            OP_AND, OP_OR,
            OP_XOR, OP_NOT,
            OP_SRA:         m = 4'b1100;
            default:        m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_skid_fifo.sv
// Two-entry FIFO with valid/ready on both sides.
// in_ready depends only on the registered occupancy; head reads as zero when empty.
module alu_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         push;
    logic         pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rd_q] : '0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the alu: NZCV status policy, sticky V,
// saturating op counter and a 2-entry output FIFO of {Y, flags}.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [N-1:0]     in_y,
    input  logic             in_z,
    input  logic             in_c,
    input  logic             in_n,
    input  logic             in_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_y,
    output logic [3:0]       out_flags,
    output logic [3:0]       status,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic             err_illegal,
    output logic [CNT_W-1:0] op_count
);

    logic             accept;
    logic             legal;
    logic             push;
    logic [3:0]       mask;
    logic [3:0]       new_flags;
    logic [3:0]       status_q;
    logic [3:0]       status_d;
    logic             sticky_q;
    logic             sticky_d;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [N+3:0]     head;

    assign accept    = in_valid & in_ready;
    assign legal     = is_legal(in_opcode);
    assign push      = accept & legal;
    assign mask      = upd_mask(in_opcode);
    assign new_flags = {in_n, in_z, in_c, in_v};

    always_comb begin
        status_d = status_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (push) begin
            status_d = (status_q & ~mask) | (new_flags & mask);
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        // A same-cycle set wins over the clear.
        if (push && mask[FLG_V] && in_v) sticky_d = 1'b1;
        else if (clr_sticky)             sticky_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 4'b0000;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            status_q <= status_d;
            sticky_q <= sticky_d;
            err_q    <= accept & ~legal;
            cnt_q    <= cnt_d;
        end
    end

    alu_skid_fifo #(.W(N + 4)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_ready  (in_ready),
        .in_data   ({in_y, status_d}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_y       = head[N+3:4];
    assign out_flags   = head[3:0];
    assign status      = status_q;
    assign sticky_v    = sticky_q;
    assign err_illegal = err_q;
    assign op_count    = cnt_q;

endmodule
